// File: rtl/logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// logic_unit_arbiter
//
// Shares one combinational bitwise logic unit (AND/OR/NOR/XOR) between two
// requesters (execute stage = requester 0, multi-cycle helper = requester 1).
// The winner's op and operands are registered onto the unit inputs, the unit's
// result is registered one cycle later and returned with a valid/ready
// handshake tagged by the owning requester's ID.
//
// Sequence per operation (res_ready held high):
//   IDLE  --edge: arbitrate, pulse gnt, load unit_* --> ISSUE
//   ISSUE --edge: capture unit_result, raise res_valid --> RESP
//   RESP  --edge: handshake, drop res_valid           --> IDLE
//
// Configuration macro:
//   LOGIC_ARB_FIXED_PRIO_EN  defined  : requester 0 always wins a tie.
//                            undefined: round-robin on ties (default).
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   req0/op0/num1_0/num2_0   requester 0 request, op, operands
//   gnt0                     one-cycle accept pulse for requester 0
//   req1/op1/num1_1/num2_1   requester 1 request, op, operands
//   gnt1                     one-cycle accept pulse for requester 1
//   unit_op/num1/num2        registered inputs to the shared logic unit
//   unit_result              combinational result from the shared logic unit
//   result/res_valid/res_id  registered result, valid flag, owning requester
//   res_ready                consumer accepts result
//   busy                     high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module logic_unit_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [1:0]       op0,
   input  logic [WIDTH-1:0] num1_0,
   input  logic [WIDTH-1:0] num2_0,
   output logic             gnt0,
   input  logic             req1,
   input  logic [1:0]       op1,
   input  logic [WIDTH-1:0] num1_1,
   input  logic [WIDTH-1:0] num2_1,
   output logic             gnt1,
   output logic [1:0]       unit_op,
   output logic [WIDTH-1:0] unit_num1,
   output logic [WIDTH-1:0] unit_num2,
   input  logic [WIDTH-1:0] unit_result,
   output logic [WIDTH-1:0] result,
   output logic             res_valid,
   output logic             res_id,
   input  logic             res_ready,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t state;
   logic   owner;     // requester that won the current operation
   logic   pick1;     // arbitration outcome: 1 = requester 1 wins

   // pick1 is only consumed when at least one request is present.
`ifdef LOGIC_ARB_FIXED_PRIO_EN
   assign pick1 = req1 & ~req0;
`else
   logic last_winner;
   // On a tie the requester that did not win last time gets the grant.
   assign pick1 = req1 & (~req0 | ~last_winner);
`endif

   // NOTE: all state and outputs are updated with non-blocking assignments so
   // every register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= 1'b0;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         unit_op   <= 2'b00;
         unit_num1 <= '0;
         unit_num2 <= '0;
         result    <= '0;
         res_valid <= 1'b0;
         res_id    <= 1'b0;
         busy      <= 1'b0;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
         last_winner <= 1'b1;  // requester 0 wins the first tie
`endif
      end else begin
         // Grants are single-cycle pulses; only the IDLE branch raises one.
         gnt0 <= 1'b0;
         gnt1 <= 1'b0;

         case (state)
            IDLE: begin
               if (req0 | req1) begin
                  gnt0      <= ~pick1;
                  gnt1      <= pick1;
                  unit_op   <= pick1 ? op1    : op0;
                  unit_num1 <= pick1 ? num1_1 : num1_0;
                  unit_num2 <= pick1 ? num2_1 : num2_0;
                  owner     <= pick1;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
                  last_winner <= pick1;
`endif
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end

            // unit_* have been stable for a full cycle; take the result.
            ISSUE: begin
               result    <= unit_result;
               res_valid <= 1'b1;
               res_id    <= owner;
               state     <= RESP;
            end

            // Hold the response until the consumer takes it. unit_* keep
            // their values; the next arbitration happens back in IDLE.
            RESP: begin
               if (res_valid && res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               res_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_arbiter
//
// Self-checking bench for logic_unit_arbiter. Each requester is a queue of
// pending operations; req is high while its queue is non-empty and the
// operand lines show the queue head (random garbage otherwise). A transaction
// level model decides, per clock edge, whether a grant happens, who wins, and
// when the result must appear and be released. The shared logic unit itself
// is modelled combinationally here, as it lives outside the DUT.
// -----------------------------------------------------------------------------
module tb_logic_unit_arbiter;

   localparam int WIDTH = 32;

   typedef struct packed {
      logic [1:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } txn_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req0, req1, gnt0, gnt1;
   logic [1:0]       op0, op1, unit_op;
   logic [WIDTH-1:0] num1_0, num2_0, num1_1, num2_1;
   logic [WIDTH-1:0] unit_num1, unit_num2, unit_result, result;
   logic             res_valid, res_id, res_ready, busy;

   logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .op0(op0), .num1_0(num1_0), .num2_0(num2_0), .gnt0(gnt0),
      .req1(req1), .op1(op1), .num1_1(num1_1), .num2_1(num2_1), .gnt1(gnt1),
      .unit_op(unit_op), .unit_num1(unit_num1), .unit_num2(unit_num2),
      .unit_result(unit_result),
      .result(result), .res_valid(res_valid), .res_id(res_id),
      .res_ready(res_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] ref_logic(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return ~(a | b);
         default: return a ^ b;
      endcase
   endfunction

   // Shared datapath outside the arbiter.
   always_comb unit_result = ref_logic(unit_op, unit_num1, unit_num2);

   // ---------------------------------------------------------------- checking
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------ requesters & model
   txn_t q0[$], q1[$];
   int   ready_pct = 100;
   int   gnt_log[$];      // DUT grants as observed, for order checks

   bit               m_free, m_issued, m_rv, m_last, m_id, m_out_id;
   txn_t             m_txn;
   logic [WIDTH-1:0] m_out_res;

   task automatic model_reset();
      m_free   = 1'b1;
      m_issued = 1'b0;
      m_rv     = 1'b0;
      m_last   = 1'b1;
      m_id     = 1'b0;
   endtask

   task automatic drive_inputs();
      req0 = (q0.size() != 0);
      req1 = (q1.size() != 0);
      if (req0) {op0, num1_0, num2_0} = q0[0];
      else      {op0, num1_0, num2_0} = {2'($urandom), $urandom, $urandom};
      if (req1) {op1, num1_1, num2_1} = q1[0];
      else      {op1, num1_1, num2_1} = {2'($urandom), $urandom, $urandom};
      res_ready = ($urandom_range(99) < ready_pct);
   endtask

   // One clock: drive inputs (at negedge), let the edge happen, predict, check.
   task automatic step();
      bit was_free, was_issued, win, eg0, eg1;
      drive_inputs();
      @(posedge clk);
      was_free   = m_free;
      was_issued = m_issued;
      eg0 = 1'b0;
      eg1 = 1'b0;
      if (was_issued) begin
         m_issued  = 1'b0;
         m_rv      = 1'b1;
         m_out_res = ref_logic(m_txn.op, m_txn.a, m_txn.b);
         m_out_id  = m_id;
      end else if (m_rv && res_ready) begin
         m_rv   = 1'b0;
         m_free = 1'b1;          // next arbitration one edge later
      end
      if (was_free && (req0 || req1)) begin
`ifdef LOGIC_ARB_FIXED_PRIO_EN
         win = !req0;
`else
         win = (req0 && req1) ? !m_last : req1;
`endif
         m_last   = win;
         m_id     = win;
         m_txn    = win ? q1.pop_front() : q0.pop_front();
         m_issued = 1'b1;
         m_free   = 1'b0;
         eg0 = !win;
         eg1 = win;
      end
      @(negedge clk);
      if (gnt0) gnt_log.push_back(0);
      if (gnt1) gnt_log.push_back(1);
      check("gnt0", gnt0, eg0);
      check("gnt1", gnt1, eg1);
      check("busy", busy, !m_free);
      check("res_valid", res_valid, m_rv);
      if (m_rv) begin
         check("result", result, m_out_res);
         check("res_id", res_id, m_out_id);
      end
      if (eg0 || eg1) begin
         check("unit_op", unit_op, m_txn.op);
         check("unit_num1", unit_num1, m_txn.a);
         check("unit_num2", unit_num2, m_txn.b);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_gnt0"}, gnt0, 0);
      check({tag, "_gnt1"}, gnt1, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_res_valid"}, res_valid, 0);
      check({tag, "_res_id"}, res_id, 0);
      check({tag, "_result"}, result, 0);
      check({tag, "_unit_op"}, unit_op, 0);
      check({tag, "_unit_num1"}, unit_num1, 0);
      check({tag, "_unit_num2"}, unit_num2, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      q0.delete();
      q1.delete();
      model_reset();
      drive_inputs();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ------------------------------------------------------------------- tests
   initial begin
      model_reset();
      drive_inputs();
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;

      // Single NOR request from requester 0.
      ready_pct = 100;
      q0.push_back('{op: 2'b10, a: 32'h0000_00F0, b: 32'h0000_000F});
      step();
      check("t1_unit_op", unit_op, 2'b10);
      step();
      check("t1_result", result, 32'hFFFF_FF00);
      check("t1_res_id", res_id, 0);
      repeat (3) step();

      // Both requesting continuously from reset: grant order.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         q0.push_back('{op: 2'($urandom), a: $urandom, b: $urandom});
         q1.push_back('{op: 2'($urandom), a: $urandom, b: $urandom});
      end
      gnt_log.delete();
      repeat (26) step();
      check("order_count", gnt_log.size(), 8);
      for (int i = 0; i < 4; i++) begin
`ifdef LOGIC_ARB_FIXED_PRIO_EN
         check($sformatf("order_%0d", i), gnt_log[i], 0);
`else
         check($sformatf("order_%0d", i), gnt_log[i], i % 2);
`endif
      end

      // Consumer stalls with requester 1 pending.
      do_reset();
      ready_pct = 0;
      q0.push_back('{op: 2'b01, a: 32'h1234_0000, b: 32'h0000_5678});
      q1.push_back('{op: 2'b00, a: 32'hFFFF_0000, b: 32'h0F0F_0F0F});
      repeat (7) step();
      check("stall_busy", busy, 1);
      check("stall_result", result, 32'h1234_5678);
      ready_pct = 100;
      repeat (8) step();

      // Requester 1 XOR; operands scrambled right after its grant.
      q1.push_back('{op: 2'b11, a: 32'hAAAA_AAAA, b: 32'hFFFF_FFFF});
      step();
      check("t4_gnt1", gnt1, 1);
      step();
      check("t4_result", result, 32'h5555_5555);
      check("t4_res_id", res_id, 1);
      repeat (3) step();

      // Reset while the operation sits in ISSUE.
      q0.push_back('{op: 2'b00, a: 32'hFFFF_FFFF, b: 32'h8000_0001});
      step();
      check("t5_gnt0", gnt0, 1);
      #2 rst = 1'b1;
      #1 check_reset_values("midreset");
      model_reset();
      q0.delete();
      q1.delete();
      drive_inputs();
      @(posedge clk);
      @(negedge clk);
      check("midreset_no_valid", res_valid, 0);
      rst = 1'b0;
      q0.push_back('{op: 2'b11, a: $urandom, b: $urandom});
      q1.push_back('{op: 2'b01, a: $urandom, b: $urandom});
      gnt_log.delete();
      repeat (8) step();
      check("after_reset_first", (gnt_log.size() != 0) ? gnt_log[0] : 9, 0);

      // Random traffic: pushes, withdrawals, random back-pressure.
      ready_pct = 70;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(99) < 25 && q0.size() < 3)
            q0.push_back('{op: 2'($urandom), a: $urandom, b: $urandom});
         if ($urandom_range(99) < 25 && q1.size() < 3)
            q1.push_back('{op: 2'($urandom), a: $urandom, b: $urandom});
         if ($urandom_range(99) < 3) q0.delete();
         if ($urandom_range(99) < 3) q1.delete();
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
